// File: rtl/wic_pmu_ctrl.sv
// Low-power sequencer: sleep ack, delayed CPU clock gating, PLL power-down for STOP, wake-up on WIC interrupt.
// Optional WIC_PMU_SLEEP_CNT_EN adds the pmu_sleep_cycles residency counter.
module wic_pmu_ctrl #(
  parameter int CLK_OFF_DLY = 4,
  parameter int WAKE_DLY    = 16,
  parameter int CNT_W       = 8
) (
  input  logic       wic_clk,
  input  logic       pad_cpu_rst,
  input  logic       cpu_pmu_sleep_req,
  input  logic       cpu_pmu_stop,
  input  logic       intraw_vld,
  output logic       pmu_cpu_sleep_ack,
  output logic       pmu_clk_gate_en,
  output logic       pmu_pll_pd,
  output logic       pmu_cpu_wakeup,
  output logic [2:0] pmu_state
`ifdef WIC_PMU_SLEEP_CNT_EN
  ,
  output logic [31:0] pmu_sleep_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACK    = 3'd1,
    S_DLY    = 3'd2,
    S_SLEEP  = 3'd3,
    S_PLL_UP = 3'd4,
    S_WAKE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(CLK_OFF_DLY - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stop;
  logic             r_ack;
  logic             r_gate;
  logic             r_pd;
  logic             r_wake;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});

  // Next-state decode; codes 6 and 7 fall into default and recover to IDLE.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_pmu_sleep_req) w_nxt = intraw_vld ? S_WAKE : S_ACK;
        else                   w_nxt = S_IDLE;
      end
      S_ACK:    w_nxt = S_DLY;
      S_DLY: begin
        if (intraw_vld)      w_nxt = S_WAKE;
        else if (w_cnt_zero) w_nxt = S_SLEEP;
        else                 w_nxt = S_DLY;
      end
      S_SLEEP: begin
        if (intraw_vld) w_nxt = r_stop ? S_PLL_UP : S_WAKE;
        else            w_nxt = S_SLEEP;
      end
      S_PLL_UP: w_nxt = w_cnt_zero ? S_WAKE : S_PLL_UP;
      S_WAKE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // State, delay counter, stop latch and outputs registered from the next-state decode.
  always_ff @(posedge wic_clk) begin
    if (pad_cpu_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_stop  <= 1'b0;
      r_ack   <= 1'b0;
      r_gate  <= 1'b0;
      r_pd    <= 1'b0;
      r_wake  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ack   <= (w_nxt == S_ACK);
      r_gate  <= (w_nxt == S_SLEEP) || (w_nxt == S_PLL_UP);
      r_pd    <= (w_nxt == S_SLEEP) && r_stop;
      r_wake  <= (w_nxt == S_WAKE);
      if (r_state == S_IDLE && cpu_pmu_sleep_req && !intraw_vld) r_stop <= cpu_pmu_stop;
      else                                                        r_stop <= r_stop;
      // Zero is tested before decrementing, so the counter never wraps.
      case (r_state)
        S_ACK:    r_cnt <= OFF_LOAD;
        S_DLY:    r_cnt <= (!intraw_vld && !w_cnt_zero) ? (r_cnt - CNT_ONE) : r_cnt;
        S_SLEEP:  r_cnt <= (intraw_vld && r_stop) ? WAKE_LOAD : r_cnt;
        S_PLL_UP: r_cnt <= w_cnt_zero ? r_cnt : (r_cnt - CNT_ONE);
        default:  r_cnt <= r_cnt;
      endcase
    end
  end

  assign pmu_cpu_sleep_ack = r_ack;
  assign pmu_clk_gate_en   = r_gate;
  assign pmu_pll_pd        = r_pd;
  assign pmu_cpu_wakeup    = r_wake;
  assign pmu_state         = r_state;

`ifdef WIC_PMU_SLEEP_CNT_EN
  logic [31:0] r_sleep_cycles;

  // Gated-clock residency: cleared when a new sequence is acknowledged, saturating.
  always_ff @(posedge wic_clk) begin
    if (pad_cpu_rst) begin
      r_sleep_cycles <= 32'd0;
    end else if (w_nxt == S_ACK) begin
      r_sleep_cycles <= 32'd0;
    end else if ((r_state == S_SLEEP || r_state == S_PLL_UP) && r_sleep_cycles != 32'hFFFF_FFFF) begin
      r_sleep_cycles <= r_sleep_cycles + 32'd1;
    end else begin
      r_sleep_cycles <= r_sleep_cycles;
    end
  end

  assign pmu_sleep_cycles = r_sleep_cycles;
`endif

endmodule

// File: tb/tb_wic_pmu_ctrl.sv
// Directed self-checking bench for wic_pmu_ctrl (default CLK_OFF_DLY=4, WAKE_DLY=16).
module tb_wic_pmu_ctrl;

  logic       wic_clk;
  logic       pad_cpu_rst;
  logic       cpu_pmu_sleep_req;
  logic       cpu_pmu_stop;
  logic       intraw_vld;
  logic       pmu_cpu_sleep_ack;
  logic       pmu_clk_gate_en;
  logic       pmu_pll_pd;
  logic       pmu_cpu_wakeup;
  logic [2:0] pmu_state;
`ifdef WIC_PMU_SLEEP_CNT_EN
  logic [31:0] pmu_sleep_cycles;
`endif

  int n_pass;
  int n_total;

  // {state, ack, gate_en, pll_pd, wakeup}
  localparam logic [6:0] E_IDLE    = 7'b000_0000;
  localparam logic [6:0] E_ACK     = 7'b001_1000;
  localparam logic [6:0] E_DLY     = 7'b010_0000;
  localparam logic [6:0] E_SLEEP_W = 7'b011_0100;
  localparam logic [6:0] E_SLEEP_S = 7'b011_0110;
  localparam logic [6:0] E_PLL_UP  = 7'b100_0100;
  localparam logic [6:0] E_WAKE    = 7'b101_0001;

  wic_pmu_ctrl dut (
    .wic_clk           (wic_clk),
    .pad_cpu_rst       (pad_cpu_rst),
    .cpu_pmu_sleep_req (cpu_pmu_sleep_req),
    .cpu_pmu_stop      (cpu_pmu_stop),
    .intraw_vld        (intraw_vld),
    .pmu_cpu_sleep_ack (pmu_cpu_sleep_ack),
    .pmu_clk_gate_en   (pmu_clk_gate_en),
    .pmu_pll_pd        (pmu_pll_pd),
    .pmu_cpu_wakeup    (pmu_cpu_wakeup),
    .pmu_state         (pmu_state)
`ifdef WIC_PMU_SLEEP_CNT_EN
    ,
    .pmu_sleep_cycles  (pmu_sleep_cycles)
`endif
  );

  initial wic_clk = 1'b0;
  always #5 wic_clk = ~wic_clk;

  function automatic logic [6:0] obs();
    return {pmu_state, pmu_cpu_sleep_ack, pmu_clk_gate_en, pmu_pll_pd, pmu_cpu_wakeup};
  endfunction

  task automatic tick();
    @(posedge wic_clk);
    #1;
  endtask

  // Drive a request through ACK and DLY into the first SLEEP cycle.
  task automatic go_sleep(input logic stop);
    cpu_pmu_sleep_req = 1'b1;
    cpu_pmu_stop = stop;
    tick();
    cpu_pmu_sleep_req = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    pad_cpu_rst = 1'b1;
    tick();
    n_total++; if (obs() !== E_IDLE) $display("FAIL reset_state: got %b want %b", obs(), E_IDLE); else n_pass++;
`ifdef WIC_PMU_SLEEP_CNT_EN
    n_total++; if (pmu_sleep_cycles !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", pmu_sleep_cycles); else n_pass++;
`endif
    pad_cpu_rst = 1'b0;
    tick();
    n_total++; if (obs() !== E_IDLE) $display("FAIL reset_release: got %b want %b", obs(), E_IDLE); else n_pass++;
  endtask

  task automatic test_wait();
    cpu_pmu_sleep_req = 1'b1;
    cpu_pmu_stop = 1'b0;
    tick();
    n_total++; if (obs() !== E_ACK) $display("FAIL wait_ack: got %b want %b", obs(), E_ACK); else n_pass++;
    cpu_pmu_sleep_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_total++; if (obs() !== E_DLY) $display("FAIL wait_dly%0d: got %b want %b", i, obs(), E_DLY); else n_pass++;
      tick();
    end
    n_total++; if (obs() !== E_SLEEP_W) $display("FAIL wait_gate: got %b want %b", obs(), E_SLEEP_W); else n_pass++;
    for (int i = 0; i < 13; i++) begin
      tick();
      n_total++; if (obs() !== E_SLEEP_W) $display("FAIL wait_hold%0d: got %b want %b", i, obs(), E_SLEEP_W); else n_pass++;
    end
    intraw_vld = 1'b1;
    tick();
    n_total++; if (obs() !== E_WAKE) $display("FAIL wait_wake: got %b want %b", obs(), E_WAKE); else n_pass++;
    intraw_vld = 1'b0;
    tick();
    n_total++; if (obs() !== E_IDLE) $display("FAIL wait_idle: got %b want %b", obs(), E_IDLE); else n_pass++;
`ifdef WIC_PMU_SLEEP_CNT_EN
    n_total++; if (pmu_sleep_cycles !== 32'd14) $display("FAIL wait_cnt: got %0d want 14", pmu_sleep_cycles); else n_pass++;
`endif
  endtask

  task automatic test_stop();
    go_sleep(1'b1);
    n_total++; if (obs() !== E_SLEEP_S) $display("FAIL stop_sleep: got %b want %b", obs(), E_SLEEP_S); else n_pass++;
    repeat (4) tick();
    intraw_vld = 1'b1;
    tick();
    n_total++; if (obs() !== E_PLL_UP) $display("FAIL stop_pllup: got %b want %b", obs(), E_PLL_UP); else n_pass++;
    for (int i = 0; i < 15; i++) begin
      if (i == 2) intraw_vld = 1'b0;
      tick();
      n_total++; if (obs() !== E_PLL_UP) $display("FAIL stop_relock%0d: got %b want %b", i, obs(), E_PLL_UP); else n_pass++;
    end
    tick();
    n_total++; if (obs() !== E_WAKE) $display("FAIL stop_wake: got %b want %b", obs(), E_WAKE); else n_pass++;
    tick();
    n_total++; if (obs() !== E_IDLE) $display("FAIL stop_idle: got %b want %b", obs(), E_IDLE); else n_pass++;
`ifdef WIC_PMU_SLEEP_CNT_EN
    n_total++; if (pmu_sleep_cycles !== 32'd21) $display("FAIL stop_cnt: got %0d want 21", pmu_sleep_cycles); else n_pass++;
`endif
  endtask

  task automatic test_abort_idle();
    cpu_pmu_sleep_req = 1'b1;
    cpu_pmu_stop = 1'b0;
    intraw_vld = 1'b1;
    tick();
    n_total++; if (obs() !== E_WAKE) $display("FAIL abort_idle_wake: got %b want %b", obs(), E_WAKE); else n_pass++;
    cpu_pmu_sleep_req = 1'b0;
    intraw_vld = 1'b0;
    tick();
    n_total++; if (obs() !== E_IDLE) $display("FAIL abort_idle_ret: got %b want %b", obs(), E_IDLE); else n_pass++;
  endtask

  task automatic test_abort_dly();
    cpu_pmu_sleep_req = 1'b1;
    cpu_pmu_stop = 1'b1;
    tick();
    n_total++; if (obs() !== E_ACK) $display("FAIL abort_dly_ack: got %b want %b", obs(), E_ACK); else n_pass++;
    cpu_pmu_sleep_req = 1'b0;
    tick();
    n_total++; if (obs() !== E_DLY) $display("FAIL abort_dly_1st: got %b want %b", obs(), E_DLY); else n_pass++;
    tick();
    n_total++; if (obs() !== E_DLY) $display("FAIL abort_dly_2nd: got %b want %b", obs(), E_DLY); else n_pass++;
    intraw_vld = 1'b1;
    tick();
    n_total++; if (obs() !== E_WAKE) $display("FAIL abort_dly_wake: got %b want %b", obs(), E_WAKE); else n_pass++;
    intraw_vld = 1'b0;
    tick();
    n_total++; if (obs() !== E_IDLE) $display("FAIL abort_dly_idle: got %b want %b", obs(), E_IDLE); else n_pass++;
`ifdef WIC_PMU_SLEEP_CNT_EN
    n_total++; if (pmu_sleep_cycles !== 32'd0) $display("FAIL abort_dly_cnt: got %0d want 0", pmu_sleep_cycles); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    cpu_pmu_sleep_req = 1'b1;
    cpu_pmu_stop = 1'b0;
    tick();
    n_total++; if (obs() !== E_ACK) $display("FAIL b2b_ack: got %b want %b", obs(), E_ACK); else n_pass++;
    repeat (5) tick();
    n_total++; if (obs() !== E_SLEEP_W) $display("FAIL b2b_sleep: got %b want %b", obs(), E_SLEEP_W); else n_pass++;
    cpu_pmu_stop = 1'b1;
    repeat (2) tick();
    n_total++; if (obs() !== E_SLEEP_W) $display("FAIL b2b_req_in_sleep: got %b want %b", obs(), E_SLEEP_W); else n_pass++;
    intraw_vld = 1'b1;
    tick();
    n_total++; if (obs() !== E_WAKE) $display("FAIL b2b_wake: got %b want %b", obs(), E_WAKE); else n_pass++;
    intraw_vld = 1'b0;
    tick();
    n_total++; if (obs() !== E_IDLE) $display("FAIL b2b_idle: got %b want %b", obs(), E_IDLE); else n_pass++;
    tick();
    n_total++; if (obs() !== E_ACK) $display("FAIL b2b_reack: got %b want %b", obs(), E_ACK); else n_pass++;
    cpu_pmu_sleep_req = 1'b0;
    tick();
    n_total++; if (obs() !== E_DLY) $display("FAIL b2b_once: got %b want %b", obs(), E_DLY); else n_pass++;
    repeat (4) tick();
    n_total++; if (obs() !== E_SLEEP_S) $display("FAIL b2b_stop_sleep: got %b want %b", obs(), E_SLEEP_S); else n_pass++;
    cpu_pmu_stop = 1'b0;
    intraw_vld = 1'b1;
    tick();
    intraw_vld = 1'b0;
    repeat (16) tick();
    n_total++; if (obs() !== E_WAKE) $display("FAIL b2b_stop_wake: got %b want %b", obs(), E_WAKE); else n_pass++;
    repeat (2) tick();
    n_total++; if (obs() !== E_IDLE) $display("FAIL b2b_final_idle: got %b want %b", obs(), E_IDLE); else n_pass++;
  endtask

  task automatic test_reset_in_sleep();
    go_sleep(1'b1);
    n_total++; if (obs() !== E_SLEEP_S) $display("FAIL rst_pre: got %b want %b", obs(), E_SLEEP_S); else n_pass++;
    pad_cpu_rst = 1'b1;
    tick();
    n_total++; if (obs() !== E_IDLE) $display("FAIL rst_sleep: got %b want %b", obs(), E_IDLE); else n_pass++;
    pad_cpu_rst = 1'b0;
    tick();
    n_total++; if (obs() !== E_IDLE) $display("FAIL rst_nowake: got %b want %b", obs(), E_IDLE); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    pad_cpu_rst = 1'b1;
    cpu_pmu_sleep_req = 1'b0;
    cpu_pmu_stop = 1'b0;
    intraw_vld = 1'b0;
    tick();
    test_reset();
    test_wait();
    test_stop();
    test_abort_idle();
    test_abort_dly();
    test_back_to_back();
    test_reset_in_sleep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
